gbf_wr_ctrl: RTL
================

GBF_WR_CTRL -- requirements
Module: gbf_wr_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 96, GBF word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, GBF write address width.
REQ-003 SHALL have parameter GRP_WIDTH, default 4, feature-group index width (2**GRP_WIDTH groups).
REQ-004 SHALL have port clk  in  1  sole clock; all logic on posedge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port Reset_FtrLay  in  1  one-cycle pulse, restart layer at group 0.
REQ-007 SHALL have port Next_FtrGrp  in  1  one-cycle pulse, advance to next feature group.
REQ-008 SHALL have port Reset_FtrGrp  in  1  one-cycle pulse, rewind to current group base.
REQ-009 SHALL have port config_paulse  in  1  read-side reconfiguration strobe.
REQ-010 SHALL have port cfg_we  in  1  base-table write enable.
REQ-011 SHALL have ports cfg_grp  in  GRP_WIDTH and cfg_base  in  ADDR_WIDTH, base-table index and absolute base address.
REQ-012 SHALL have ports in_vld  in  1, in_dat  in  DATA_WIDTH and in_rdy  out  1, upstream word stream.
REQ-013 SHALL have ports GBF_EnWr  out  1, GBF_AddrWr  out  ADDR_WIDTH and GBF_DatWr  out  DATA_WIDTH, GBF write port.
REQ-014 SHALL have ports cur_grp  out  GRP_WIDTH, busy  out  1 (command pending) and ovf_err  out  1 (sticky).

Function
REQ-015 SHALL hold a 2**GRP_WIDTH-entry base table written on cfg_we in any state, with the new value visible the next cycle.
REQ-016 SHALL implement FSM states RUN, WAIT and APPLY.
REQ-017 In RUN: in_rdy=1; a transfer (in_vld&in_rdy) in cycle n SHALL produce GBF_EnWr=1 in cycle n+1, with GBF_DatWr=in_dat and GBF_AddrWr=write pointer; the pointer then increments.
REQ-018 The write pointer SHALL wrap from 2**ADDR_WIDTH-1 to 0.
REQ-019 A command pulse in RUN SHALL latch a pending command, go to WAIT, and drop in_rdy the next cycle; a transfer in the pulse cycle itself SHALL still be written at the old pointer.
REQ-020 Simultaneous pulses SHALL resolve with priority Reset_FtrLay > Next_FtrGrp > Reset_FtrGrp.
REQ-021 In WAIT: in_rdy=0 and busy=1.
REQ-022 In WAIT, a higher-priority pulse SHALL replace the pending command; an equal- or lower-priority pulse SHALL be ignored.
REQ-023 WAIT SHALL exit to APPLY on the first falling edge of config_paulse (registered high, now low) seen after entry.
REQ-024 APPLY SHALL last one cycle with in_rdy=0, busy=1, then return to RUN.
REQ-025 APPLY with Reset_FtrLay SHALL set cur_grp=0 and pointer=0, and clear ovf_err.
REQ-026 APPLY with Next_FtrGrp SHALL set cur_grp=cur_grp+1 (wrapping from max to 0) and pointer=base[new cur_grp].
REQ-027 APPLY with Reset_FtrGrp SHALL set pointer=base[cur_grp].
REQ-028 GBF_EnWr SHALL be 0 in every cycle not following a transfer.

Reset
REQ-029 rst SHALL force state=RUN, pointer=0, cur_grp=0, pending command cleared, GBF_EnWr=0, GBF_AddrWr=0, GBF_DatWr=0, busy=0 and ovf_err=0.
REQ-030 rst SHALL set the base table to all zeros.
REQ-031 rst asserted mid-WAIT or mid-APPLY SHALL discard the pending command.
REQ-032 in_rdy SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-033 With macro GBF_WR_BOUND_CHECK_EN defined, a transfer in RUN whose pointer equals base[cur_grp+1] (cur_grp < max) SHALL be dropped: no GBF_EnWr, pointer unchanged, in_rdy still 1, and ovf_err set sticky until rst or an applied Reset_FtrLay.
REQ-034 With GBF_WR_BOUND_CHECK_EN undefined, no bound check SHALL exist, ovf_err SHALL be tied 0, and the port SHALL remain present.

Verification
REQ-035 After rst, stream 3 words A,B,C back-to-back -> GBF_EnWr high 3 cycles at addresses 0,1,2 with data A,B,C, each one cycle after its transfer.
REQ-036 base[1]=0x100, Next_FtrGrp pulse, config_paulse high 2 cycles then low -> in_rdy=0 until one cycle after APPLY, cur_grp=1, next write at 0x100.
REQ-037 Write 5 words in group 1 (base 0x100), Reset_FtrGrp, config_paulse fall -> next write at 0x100.
REQ-038 Reset_FtrGrp and Next_FtrGrp same cycle, then Reset_FtrLay while in WAIT -> on config_paulse fall, cur_grp=0, next write at 0.
REQ-039 Pointer at 0xFFF, 2 transfers -> writes at 0xFFF then 0x000; cur_grp=max then Next_FtrGrp -> cur_grp=0.
REQ-040 With GBF_WR_BOUND_CHECK_EN: base[0]=0, base[1]=2, 3 transfers in group 0 -> writes at 0,1, third dropped, ovf_err=1; rst in WAIT -> busy=0, ovf_err=0.

Source files
------------

// File: rtl/gbf_wr_ctrl.sv
// GBF write-side address controller: one registered write per accepted word, per-group base table, command/handshake FSM.
// Write appears one cycle after transfer; in_rdy low while a command waits for config_paulse to fall. Optional GBF_WR_BOUND_CHECK_EN.
module gbf_wr_ctrl #(
    parameter int DATA_WIDTH = 96,
    parameter int ADDR_WIDTH = 12,
    parameter int GRP_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Reset_FtrLay,
    input  logic                  Next_FtrGrp,
    input  logic                  Reset_FtrGrp,
    input  logic                  config_paulse,
    input  logic                  cfg_we,
    input  logic [GRP_WIDTH-1:0]  cfg_grp,
    input  logic [ADDR_WIDTH-1:0] cfg_base,
    input  logic                  in_vld,
    input  logic [DATA_WIDTH-1:0] in_dat,
    output logic                  in_rdy,
    output logic                  GBF_EnWr,
    output logic [ADDR_WIDTH-1:0] GBF_AddrWr,
    output logic [DATA_WIDTH-1:0] GBF_DatWr,
    output logic [GRP_WIDTH-1:0]  cur_grp,
    output logic                  busy,
    output logic                  ovf_err
);
    localparam int NGRP = 2**GRP_WIDTH;

    typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_APPLY} state_t;
    // Encoding order doubles as priority: a larger value wins.
    typedef enum logic [1:0] {CMD_NONE, CMD_GRP, CMD_NXT, CMD_LAY} cmd_t;

    state_t                r_state, w_state_nxt;
    cmd_t                  r_cmd, w_cmd_in;
    logic                  r_cfg_q;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] r_base [NGRP];
    logic [GRP_WIDTH-1:0]  r_grp, w_grp_inc;
    logic                  r_en;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_dat;
    logic                  w_drop, w_xfer;

    assign w_cmd_in  = Reset_FtrLay ? CMD_LAY :
                       Next_FtrGrp  ? CMD_NXT :
                       Reset_FtrGrp ? CMD_GRP : CMD_NONE;
    assign w_grp_inc = r_grp + 1'b1;

`ifdef GBF_WR_BOUND_CHECK_EN
    // Pointer reaching the next group's base means this group is full.
    assign w_drop = (r_grp != '1) && (r_ptr == r_base[w_grp_inc]);
`else
    assign w_drop = 1'b0;
`endif

    assign in_rdy     = (r_state == ST_RUN);
    assign busy       = (r_state != ST_RUN);
    assign w_xfer     = in_vld & in_rdy & ~w_drop;
    assign GBF_EnWr   = r_en;
    assign GBF_AddrWr = r_addr;
    assign GBF_DatWr  = r_dat;
    assign cur_grp    = r_grp;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_RUN;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:   if (w_cmd_in != CMD_NONE) w_state_nxt = ST_WAIT;
            ST_WAIT:  if (r_cfg_q && !config_paulse) w_state_nxt = ST_APPLY;
            ST_APPLY: w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NGRP; i++) r_base[i] <= '0;
        end else if (cfg_we) begin
            r_base[cfg_grp] <= cfg_base;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd   <= CMD_NONE;
            r_cfg_q <= 1'b0;
            r_ptr   <= '0;
            r_grp   <= '0;
            r_en    <= 1'b0;
            r_addr  <= '0;
            r_dat   <= '0;
        end else begin
            r_cfg_q <= config_paulse;
            r_en    <= w_xfer;
            if (w_xfer) begin
                r_addr <= r_ptr;
                r_dat  <= in_dat;
            end
            case (r_state)
                ST_RUN: begin
                    if (w_xfer) r_ptr <= r_ptr + 1'b1;
                    if (w_cmd_in != CMD_NONE) r_cmd <= w_cmd_in;
                end
                ST_WAIT: begin
                    if (w_cmd_in > r_cmd) r_cmd <= w_cmd_in;
                end
                ST_APPLY: begin
                    case (r_cmd)
                        CMD_LAY: begin
                            r_grp <= '0;
                            r_ptr <= '0;
                        end
                        CMD_NXT: begin
                            r_grp <= w_grp_inc;
                            r_ptr <= r_base[w_grp_inc];
                        end
                        CMD_GRP: r_ptr <= r_base[r_grp];
                        default: ;
                    endcase
                    r_cmd <= CMD_NONE;
                end
                default: ;
            endcase
        end
    end

`ifdef GBF_WR_BOUND_CHECK_EN
    logic r_ovf;
    always_ff @(posedge clk) begin
        if (rst)                                        r_ovf <= 1'b0;
        else if (r_state == ST_APPLY && r_cmd == CMD_LAY) r_ovf <= 1'b0;
        else if (in_vld && in_rdy && w_drop)            r_ovf <= 1'b1;
    end
    assign ovf_err = r_ovf;
`else
    assign ovf_err = 1'b0;
`endif
endmodule
